// File: rtl/reg_select_ctrl.sv
// Register-select decoder: IR fields -> one-hot R/W enables, R0 base-address zero, write scoreboard.
// Latency 1 clk on every output; no backpressure, reads of busy registers are dropped and flagged via stall.
module reg_select_ctrl #(
  parameter int NREGS  = 16,
  parameter int IDX_W  = 4,
  parameter int RA_LSB = 23,
  parameter int RB_LSB = 19,
  parameter int RC_LSB = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      IR,
  input  logic             IRin,
  input  logic             Gra,
  input  logic             Grb,
  input  logic             Grc,
  input  logic             Rin,
  input  logic             Rout,
  input  logic             BAout,
  input  logic             mark,
  input  logic             err_clr,
  output logic [NREGS-1:0] Rin_vec,
  output logic [NREGS-1:0] Rout_vec,
  output logic             ba_zero,
  output logic             stall,
  output logic [NREGS-1:0] busy,
  output logic             err
);

  localparam logic [NREGS-1:0] ONE = {{(NREGS-1){1'b0}}, 1'b1};

  logic [31:0]      ir_q;
  logic [IDX_W-1:0] ra_idx;
  logic [IDX_W-1:0] rb_idx;
  logic [IDX_W-1:0] rc_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic [NREGS-1:0] sel_onehot;
  logic [NREGS-1:0] ra_onehot;
  logic             sel_busy;
  logic             ba_r0;
  logic             read_req;
  logic             write_acc;

  logic [NREGS-1:0] rin_nxt;
  logic [NREGS-1:0] rout_nxt;
  logic             ba_nxt;
  logic             stall_nxt;
  logic [NREGS-1:0] busy_set;
  logic [NREGS-1:0] busy_clr;
  logic [NREGS-1:0] busy_nxt;
  logic             multi_sel;
  logic             violation;
  logic             err_nxt;

  // Only the three register fields of ir_q are decoded.
  logic ir_unused;
  assign ir_unused = ^ir_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ir_q <= '0;
    end else if (IRin) begin
      ir_q <= IR;
    end
  end

  assign ra_idx = ir_q[RA_LSB +: IDX_W];
  assign rb_idx = ir_q[RB_LSB +: IDX_W];
  assign rc_idx = ir_q[RC_LSB +: IDX_W];

  always_comb begin
    sel_idx = rc_idx;
    if (Gra) begin
      sel_idx = ra_idx;
    end else if (Grb) begin
      sel_idx = rb_idx;
    end
  end

  assign sel_any    = Gra | Grb | Grc;
  assign sel_onehot = ONE << sel_idx;
  assign ra_onehot  = ONE << ra_idx;
  assign sel_busy   = busy[sel_idx];
  assign read_req   = Rout | BAout;
  assign ba_r0      = BAout && (sel_idx == '0);
  assign write_acc  = sel_any & Rin;

  // Write beats read; BAout on R0 bypasses the register file so it never stalls.
  always_comb begin
    rin_nxt   = '0;
    rout_nxt  = '0;
    ba_nxt    = 1'b0;
    stall_nxt = 1'b0;
    if (sel_any) begin
      if (Rin) begin
        rin_nxt = sel_onehot;
      end else if (ba_r0) begin
        ba_nxt = 1'b1;
      end else if (read_req) begin
        if (sel_busy) begin
          stall_nxt = 1'b1;
        end else begin
          rout_nxt = sel_onehot;
        end
      end
    end
  end

  // Set is OR-ed after the clear so a same-edge mark keeps the register pending.
  always_comb begin
    busy_set = mark ? ra_onehot : '0;
    busy_clr = write_acc ? sel_onehot : '0;
    busy_nxt = (busy & ~busy_clr) | busy_set;
  end

  always_comb begin
    multi_sel = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);
    violation = multi_sel | (Rin & (Rout | BAout)) | (Rout & BAout);
    err_nxt   = err;
    if (violation) begin
      err_nxt = 1'b1;
    end else if (err_clr) begin
      err_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      Rin_vec  <= '0;
      Rout_vec <= '0;
      ba_zero  <= 1'b0;
      stall    <= 1'b0;
      busy     <= '0;
      err      <= 1'b0;
    end else begin
      Rin_vec  <= rin_nxt;
      Rout_vec <= rout_nxt;
      ba_zero  <= ba_nxt;
      stall    <= stall_nxt;
      busy     <= busy_nxt;
      err      <= err_nxt;
    end
  end

endmodule
